// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared types and constants for the PS/2 host transmitter and
//                its line conditioning. Holds the FSM state type, error codes,
//                common keyboard command/response bytes and a parity helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  // Transmitter FSM states; S_END is the single pulse cycle before IDLE
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_REQ       = 3'd2,
    S_DATA      = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5,
    S_END       = 3'd6
  } ps2_tx_state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_START = 2'b01;
  localparam logic [1:0] ERR_XFER  = 2'b10;
  localparam logic [1:0] ERR_NOACK = 2'b11;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_RESEND = 8'hFE;

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_line_sync
//  Description : Two-flop synchronizers for the PS/2 clock and data lines and
//                a falling-edge pulse on the synchronized clock. Reset values
//                are the idle-high line state so no edge is seen after reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_clk_raw,
  input  logic i_dat_raw,
  output logic o_clk_sync,
  output logic o_dat_sync,
  output logic o_clk_fe
);

  logic r_clk_meta;
  logic r_clk_sync;
  logic r_clk_prev;
  logic r_dat_meta;
  logic r_dat_sync;

  // Synchronize both lines and keep one delayed copy of the clock for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
    end else begin
      r_clk_meta <= i_clk_raw;
      r_clk_sync <= r_clk_meta;
      r_clk_prev <= r_clk_sync;
      r_dat_meta <= i_dat_raw;
      r_dat_sync <= r_dat_meta;
    end
  end

  assign o_clk_sync = r_clk_sync;
  assign o_dat_sync = r_dat_sync;
  assign o_clk_fe   = r_clk_prev & ~r_clk_sync;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx
//  Description : PS/2 host-to-device command transmitter. Runs inhibit and
//                request-to-send, shifts data/parity/stop on device clock
//                falling edges, checks the device ACK and reports done/error.
//                Optional build macro PS2_TX_RETRY_EN retries start-timeout
//                and no-ACK failures up to MAX_RETRIES times.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES       = 6000,
  parameter int unsigned START_TIMEOUT_CYCLES = 750000,
  parameter int unsigned XFER_TIMEOUT_CYCLES  = 100000,
  parameter int unsigned MAX_RETRIES          = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code
);

  localparam int unsigned c_TMR_MAX0 = (START_TIMEOUT_CYCLES > XFER_TIMEOUT_CYCLES) ?
                                       START_TIMEOUT_CYCLES : XFER_TIMEOUT_CYCLES;
  localparam int unsigned c_TMR_MAX  = (c_TMR_MAX0 > INHIBIT_CYCLES) ? c_TMR_MAX0 : INHIBIT_CYCLES;
  localparam int          c_TMR_W    = $clog2(c_TMR_MAX + 1);
  localparam logic [c_TMR_W-1:0] c_INH_LAST   = c_TMR_W'(INHIBIT_CYCLES - 1);
  localparam logic [c_TMR_W-1:0] c_START_LAST = c_TMR_W'(START_TIMEOUT_CYCLES - 1);
  localparam logic [c_TMR_W-1:0] c_XFER_LAST  = c_TMR_W'(XFER_TIMEOUT_CYCLES - 1);

  ps2_tx_state_t      r_state, w_state_nx;
  logic               r_clk_oe, w_clk_oe_nx;
  logic               r_dat_oe, w_dat_oe_nx;
  logic [8:0]         r_shreg, w_shreg_nx;
  logic [3:0]         r_bitcnt, w_bitcnt_nx;
  logic [c_TMR_W-1:0] r_timer, w_timer_nx;
  logic               r_done, w_done_nx;
  logic               r_error, w_error_nx;
  logic [1:0]         r_err_code, w_err_code_nx;
  logic               w_fail;
  logic [1:0]         w_fail_code;
  logic               w_in_xfer;
  logic               w_clk_s, w_dat_s, w_fe;

`ifdef PS2_TX_RETRY_EN
  localparam int c_RTY_W = (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam logic [c_RTY_W-1:0] c_RTY_LIMIT = c_RTY_W'(MAX_RETRIES);
  logic [c_RTY_W-1:0] r_retry, w_retry_nx;
  logic [7:0]         r_byte, w_byte_nx;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (MAX_RETRIES != 0);
`endif

  ps2_line_sync u_sync (
    .clk        (clock),
    .rst        (reset),
    .i_clk_raw  (ps2_clk_in),
    .i_dat_raw  (ps2_dat_in),
    .o_clk_sync (w_clk_s),
    .o_dat_sync (w_dat_s),
    .o_clk_fe   (w_fe)
  );

  // The transfer timer covers everything from the first device edge until the lines idle
  assign w_in_xfer = (r_state == S_DATA) || (r_state == S_ACK) || (r_state == S_WAIT_IDLE);

  // Next-state, datapath and pulse decisions
  always_comb begin
    w_state_nx    = r_state;
    w_clk_oe_nx   = r_clk_oe;
    w_dat_oe_nx   = r_dat_oe;
    w_shreg_nx    = r_shreg;
    w_bitcnt_nx   = r_bitcnt;
    w_timer_nx    = r_timer;
    w_done_nx     = 1'b0;
    w_error_nx    = 1'b0;
    w_err_code_nx = r_err_code;
    w_fail        = 1'b0;
    w_fail_code   = ERR_NONE;
`ifdef PS2_TX_RETRY_EN
    w_retry_nx    = r_retry;
    w_byte_nx     = r_byte;
`endif
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_shreg_nx  = {odd_parity(cmd_byte), cmd_byte};
          w_bitcnt_nx = '0;
          w_timer_nx  = '0;
          w_clk_oe_nx = 1'b1;
          w_dat_oe_nx = 1'b0;
          w_state_nx  = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          w_retry_nx  = '0;
          w_byte_nx   = cmd_byte;
`endif
        end
      end
      S_INHIBIT: begin
        // Device edges are ignored here: the clock line is held low by us
        if (r_timer == c_INH_LAST) begin
          w_timer_nx  = '0;
          w_clk_oe_nx = 1'b0;
          w_dat_oe_nx = 1'b1;
          w_state_nx  = S_REQ;
        end else begin
          w_timer_nx = r_timer + c_TMR_W'(1);
        end
      end
      S_REQ: begin
        if (w_fe) begin
          w_dat_oe_nx = ~r_shreg[0];
          w_shreg_nx  = {1'b0, r_shreg[8:1]};
          w_bitcnt_nx = 4'd1;
          w_timer_nx  = '0;
          w_state_nx  = S_DATA;
        end else if (r_timer == c_START_LAST) begin
          w_fail      = 1'b1;
          w_fail_code = ERR_START;
        end else begin
          w_timer_nx = r_timer + c_TMR_W'(1);
        end
      end
      S_DATA: begin
        w_timer_nx = r_timer + c_TMR_W'(1);
        if (w_fe) begin
          if (r_bitcnt == 4'd9) begin
            w_dat_oe_nx = 1'b0;
            w_state_nx  = S_ACK;
          end else begin
            w_dat_oe_nx = ~r_shreg[0];
            w_shreg_nx  = {1'b0, r_shreg[8:1]};
            w_bitcnt_nx = r_bitcnt + 4'd1;
          end
        end
      end
      S_ACK: begin
        w_timer_nx = r_timer + c_TMR_W'(1);
        if (w_fe) begin
          if (!w_dat_s) begin
            w_state_nx = S_WAIT_IDLE;
          end else begin
            w_fail      = 1'b1;
            w_fail_code = ERR_NOACK;
          end
        end
      end
      S_WAIT_IDLE: begin
        w_timer_nx = r_timer + c_TMR_W'(1);
        if (w_clk_s && w_dat_s) begin
          w_done_nx  = 1'b1;
          w_state_nx = S_END;
        end
      end
      S_END: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase

    // A transfer timeout overrides anything else decided in the same cycle
    if (w_in_xfer && (r_timer == c_XFER_LAST)) begin
      w_fail      = 1'b1;
      w_fail_code = ERR_XFER;
      w_done_nx   = 1'b0;
    end

    if (w_fail) begin
`ifdef PS2_TX_RETRY_EN
      if ((w_fail_code != ERR_XFER) && (r_retry < c_RTY_LIMIT)) begin
        w_retry_nx  = r_retry + c_RTY_W'(1);
        w_shreg_nx  = {odd_parity(r_byte), r_byte};
        w_bitcnt_nx = '0;
        w_timer_nx  = '0;
        w_clk_oe_nx = 1'b1;
        w_dat_oe_nx = 1'b0;
        w_state_nx  = S_INHIBIT;
      end else begin
        w_clk_oe_nx   = 1'b0;
        w_dat_oe_nx   = 1'b0;
        w_error_nx    = 1'b1;
        w_err_code_nx = w_fail_code;
        w_state_nx    = S_END;
      end
`else
      w_clk_oe_nx   = 1'b0;
      w_dat_oe_nx   = 1'b0;
      w_error_nx    = 1'b1;
      w_err_code_nx = w_fail_code;
      w_state_nx    = S_END;
`endif
    end
  end

  // State and datapath registers; reset releases both lines immediately
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_clk_oe   <= 1'b0;
      r_dat_oe   <= 1'b0;
      r_shreg    <= '0;
      r_bitcnt   <= '0;
      r_timer    <= '0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_state    <= w_state_nx;
      r_clk_oe   <= w_clk_oe_nx;
      r_dat_oe   <= w_dat_oe_nx;
      r_shreg    <= w_shreg_nx;
      r_bitcnt   <= w_bitcnt_nx;
      r_timer    <= w_timer_nx;
      r_done     <= w_done_nx;
      r_error    <= w_error_nx;
      r_err_code <= w_err_code_nx;
    end
  end

`ifdef PS2_TX_RETRY_EN
  // Retry bookkeeping: attempt count and the byte to resend
  always_ff @(posedge clock) begin
    if (reset) begin
      r_retry <= '0;
      r_byte  <= '0;
    end else begin
      r_retry <= w_retry_nx;
      r_byte  <= w_byte_nx;
    end
  end
`endif

  assign cmd_ready  = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign ps2_clk_oe = r_clk_oe;
  assign ps2_dat_oe = r_dat_oe;
  assign done       = r_done;
  assign error      = r_error;
  assign err_code   = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_host_tx
//  Description : Self-checking bench for ps2_host_tx with a behavioural PS/2
//                device model on wired-AND lines and a frame reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH      = 16;
  localparam int START_TO = 200;
  localparam int XFER_TO  = 400;
  localparam int HALF     = 6;
`ifdef PS2_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] cmd_byte = 8'h00;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready, ps2_clk_oe, ps2_dat_oe, busy, done, error;
  logic [1:0] err_code;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps2_clk_in, ps2_dat_in;

  // Open-collector lines: either side may pull low
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES       (INH),
    .START_TIMEOUT_CYCLES (START_TO),
    .XFER_TIMEOUT_CYCLES  (XFER_TO),
    .MAX_RETRIES          (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_byte   (cmd_byte),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_code   (err_code)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Reference frame seen by the device: data LSB first, odd parity, stop
  function automatic logic [9:0] ref_frame(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (b[i]) ones++;
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b};
  endfunction

  // Event monitor
  int         n_cyc = 0, n_done = 0, n_err = 0, n_inh = 0, n_clkoe_cyc = 0;
  int         err_cyc = 0;
  logic       prev_clk_oe = 1'b0;
  logic [1:0] err_code_cap = 2'b00;
  logic [1:0] oe_cap = 2'b00;
  logic       busy_after_err = 1'b0;
  bit         err_pending = 1'b0;

  always @(negedge clock) begin
    n_cyc++;
    if (!reset) begin
      if (err_pending) begin
        busy_after_err = busy;
        err_pending = 1'b0;
      end
      if (done) n_done++;
      if (error) begin
        n_err++;
        err_cyc = n_cyc;
        err_code_cap = err_code;
        oe_cap = {ps2_clk_oe, ps2_dat_oe};
        err_pending = 1'b1;
      end
      if (ps2_clk_oe && !prev_clk_oe) n_inh++;
      if (ps2_clk_oe) begin
        n_clkoe_cyc++;
        check_eq("clk_oe_only_busy", 32'(busy), 32'd1);
      end
      if (done || error) check_eq("pulse_excl_ready", 32'({done & error, cmd_ready}), 32'd0);
    end
    prev_clk_oe = ps2_clk_oe;
  end

  int fall_cyc = 0;
  int acc_cyc = 0;

  task automatic send_cmd(input logic [7:0] b);
    check_eq("ready_before", 32'(cmd_ready), 32'd1);
    cmd_byte = b;
    cmd_valid = 1'b1;
    tick(1);
    cmd_valid = 1'b0;
    acc_cyc = n_cyc;
    check_eq("accept_busy", 32'(busy), 32'd1);
    check_eq("accept_clk_oe", 32'(ps2_clk_oe), 32'd1);
    check_eq("accept_ready", 32'(cmd_ready), 32'd0);
  endtask

  // Device: wait for request, clock npulse bits; with npulse > 10 also give the ACK pulse
  task automatic device_xfer(input int npulse, input bit ack_low, output logic [9:0] cap);
    int  c = 0;
    bit  seen;
    cap = '0;
    while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && c < INH * 4 + 100) begin
      tick(1);
      c++;
    end
    seen = (ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1);
    check_eq("request_seen", 32'(seen), 32'd1);
    if (!seen) return;
    check_eq("start_bit_low", 32'(ps2_dat_in), 32'd0);
    tick(4);
    for (int k = 0; k < npulse && k < 10; k++) begin
      dev_clk = 1'b0;
      if (k == 0) fall_cyc = n_cyc;
      tick(HALF);
      dev_clk = 1'b1;
      cap[k] = ps2_dat_in;
      tick(HALF);
    end
    if (npulse > 10) begin
      dev_dat = ack_low ? 1'b0 : 1'b1;
      tick(HALF);
      dev_clk = 1'b0;
      tick(HALF);
      dev_clk = 1'b1;
      tick(2);
      dev_dat = 1'b1;
    end
  endtask

  task automatic wait_result(input int budget, input int snap);
    int c = 0;
    while ((n_done + n_err) == snap && c < budget) begin
      tick(1);
      c++;
    end
    check_eq("result_seen", 32'((n_done + n_err) != snap), 32'd1);
  endtask

  task automatic run_normal(input logic [7:0] b);
    logic [9:0] cap;
    int sd, se, soe;
    sd = n_done; se = n_err; soe = n_clkoe_cyc;
    send_cmd(b);
    tick(2);
    cmd_byte = ~b;
    cmd_valid = 1'b1;
    tick(1);
    cmd_valid = 1'b0;
    device_xfer(11, 1'b1, cap);
    wait_result(200, sd + se);
    check_eq("frame", 32'(cap), 32'(ref_frame(b)));
    check_eq("done_count", 32'(n_done - sd), 32'd1);
    check_eq("err_count", 32'(n_err - se), 32'd0);
    check_eq("inhibit_len", 32'(n_clkoe_cyc - soe), 32'(INH));
    tick(3);
    check_eq("ready_after", 32'(cmd_ready), 32'd1);
    check_eq("busy_after", 32'(busy), 32'd0);
    check_eq("no_queue", 32'(ps2_clk_oe), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] cap;
    logic [7:0] b;
    int sd, se, si, lat, lo, hi;

    // Reset state
    tick(3);
    check_eq("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check_eq("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
    reset = 1'b0;
    tick(1);
    check_eq("rst_ready", 32'(cmd_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_pulses", 32'({done, error}), 32'd0);
    check_eq("rst_err_code", 32'(err_code), 32'd0);

    // Normal transfers: fixed parity corners, then random bytes
    run_normal(CMD_SET_LEDS);
    run_normal(8'h00);
    run_normal(8'hFF);
    run_normal(8'h01);
    for (int i = 0; i < 4; i++) run_normal(8'($urandom));

    // Device never clocks: start timeout
    sd = n_done; se = n_err; si = n_inh;
    send_cmd(8'($urandom));
    wait_result(ATTEMPTS * (INH + START_TO) + 100, sd + se);
    tick(2);
    lat = err_cyc - acc_cyc;
    lo = ATTEMPTS * (INH + START_TO) - 2;
    hi = ATTEMPTS * (INH + START_TO) + 4;
    check_eq("start_to_latency", 32'((lat >= lo && lat <= hi) ? 1 : 0), 32'd1);
    check_eq("start_to_code", 32'(err_code_cap), 32'(ERR_START));
    check_eq("start_to_oe", 32'(oe_cap), 32'd0);
    check_eq("start_to_busy_next", 32'(busy_after_err), 32'd0);
    check_eq("start_to_err_cnt", 32'(n_err - se), 32'd1);
    check_eq("start_to_done_cnt", 32'(n_done - sd), 32'd0);
    check_eq("start_to_inhibits", 32'(n_inh - si), 32'(ATTEMPTS));

    // Device does not ACK
    sd = n_done; se = n_err; si = n_inh;
    b = 8'($urandom);
    send_cmd(b);
    for (int a = 0; a < ATTEMPTS; a++) begin
      device_xfer(11, 1'b0, cap);
      check_eq("noack_frame", 32'(cap), 32'(ref_frame(b)));
    end
    wait_result(200, sd + se);
    tick(2);
    check_eq("noack_code", 32'(err_code_cap), 32'(ERR_NOACK));
    check_eq("noack_oe", 32'(oe_cap), 32'd0);
    check_eq("noack_err_cnt", 32'(n_err - se), 32'd1);
    check_eq("noack_done_cnt", 32'(n_done - sd), 32'd0);
    check_eq("noack_inhibits", 32'(n_inh - si), 32'(ATTEMPTS));

    // Device stops after 4 bits: transfer timeout, never retried
    tick(5);
    check_eq("err_code_hold", 32'(err_code), 32'(ERR_NOACK));
    sd = n_done; se = n_err; si = n_inh;
    send_cmd(8'($urandom));
    device_xfer(4, 1'b1, cap);
    wait_result(XFER_TO + 100, sd + se);
    tick(2);
    lat = err_cyc - fall_cyc;
    check_eq("xfer_to_latency", 32'((lat >= XFER_TO && lat <= XFER_TO + 6) ? 1 : 0), 32'd1);
    check_eq("xfer_to_code", 32'(err_code_cap), 32'(ERR_XFER));
    check_eq("xfer_to_oe", 32'(oe_cap), 32'd0);
    check_eq("xfer_to_err_cnt", 32'(n_err - se), 32'd1);
    check_eq("xfer_to_inhibits", 32'(n_inh - si), 32'd1);

    // Reset while bit index 4 (fifth bit) is driven low
    b = 8'($urandom) & 8'hEF;
    send_cmd(b);
    device_xfer(5, 1'b1, cap);
    check_eq("pre_reset_bits", 32'(cap[4:0]), 32'(b[4:0]));
    check_eq("pre_reset_dat_oe", 32'(ps2_dat_oe), 32'd1);
    sd = n_done; se = n_err;
    reset = 1'b1;
    tick(1);
    check_eq("reset_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check_eq("reset_dat_oe", 32'(ps2_dat_oe), 32'd0);
    reset = 1'b0;
    tick(20);
    check_eq("reset_no_pulse", 32'((n_done - sd) + (n_err - se)), 32'd0);
    check_eq("reset_err_code", 32'(err_code), 32'd0);
    run_normal(CMD_RESET);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It sends one command byte (for example 0xED set-LEDs, or 0xFF reset) to the keyboard over the same two open-collector lines the keyboard receiver listens on. It runs the inhibit / request-to-send sequence, shifts out data, odd parity and stop on device clock edges, then checks the device ACK bit. It sits beside read_keyboard at the top level; the top-level tristate buffers turn its pull-low enables into drive.

Parameters:
- INHIBIT_CYCLES, 6000, clock-line hold-low time before request (120 us at 50 MHz).
- START_TIMEOUT_CYCLES, 750000, maximum wait for the first device clock falling edge after request (15 ms).
- XFER_TIMEOUT_CYCLES, 100000, maximum time from the first falling edge to the ACK (2 ms).
- MAX_RETRIES, 2, retry count (used only with the optional feature).

Ports:
- clock  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high reset.
- cmd_byte  in  8  byte to send; sampled when cmd_valid && cmd_ready.
- cmd_valid  in  1  request strobe.
- cmd_ready  out  1  high only in IDLE.
- ps2_clk_in  in  1  raw PS2 clock line (asynchronous).
- ps2_dat_in  in  1  raw PS2 data line (asynchronous).
- ps2_clk_oe  out  1  1 = pull clock low; 0 = release.
- ps2_dat_oe  out  1  1 = pull data low; 0 = release.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the ACK is received.
- error  out  1  one-cycle pulse on failure.
- err_code  out  2  valid with error: 01 start timeout, 10 transfer timeout, 11 no ACK; holds its last value otherwise.

Behaviour:
- Reset:
  - State goes to IDLE.
  - ps2_clk_oe = 0, ps2_dat_oe = 0, done = 0, error = 0, err_code = 00.
  - cmd_ready = 1 from the first cycle after reset deasserts.
- Input conditioning:
  - Both line inputs pass through a 2-flop synchronizer.
  - A falling edge (fe) is the synchronized clock going 1 -> 0; detection adds 2 cycles of latency.
- Shift and parity:
  - shreg loads {odd parity, cmd_byte} on accept.
  - Parity = ~^cmd_byte.
  - Bits go out LSB first.
- States:
  - IDLE: on cmd_valid, latch the byte, clear the counters, go to INHIBIT. clk_oe = 1 starts on the next cycle.
  - INHIBIT: clk_oe = 1 for INHIBIT_CYCLES. On the final cycle set dat_oe = 1 (start bit) and go to REQ.
  - REQ: dat_oe = 1, clk_oe = 0.
    - Wait for fe.
    - On fe: dat_oe = ~shreg[0], shift, bitcnt = 1, go to DATA.
    - Timer reaches START_TIMEOUT_CYCLES: error with code 01.
  - DATA: on each fe, drive the next bit; bitcnt counts 1..9 (8 data bits plus parity). On the fe after parity, dat_oe = 0 (stop bit), go to ACK.
  - ACK: on the next fe, sample synchronized data.
    - Data = 0: go to WAIT_IDLE.
    - Data = 1: error with code 11.
  - WAIT_IDLE: wait until both synchronized lines are 1, then pulse done and go to IDLE.
  - Transfer timeout: the timer runs from entry to DATA until WAIT_IDLE exits. Reaching XFER_TIMEOUT_CYCLES gives error with code 10.
  - Any error: both oe signals go to 0, error pulses, return to IDLE.
- Boundary conditions:
  - cmd_valid outside IDLE is ignored; there is no queueing.
  - A fe seen during INHIBIT is ignored, because the device is inhibited.
  - Reset mid-transfer releases both lines in the same cycle it is sampled; no done or error pulse is produced.
  - done and error are mutually exclusive and never fire in the same cycle as cmd_ready going high. IDLE is entered the cycle after the pulse.
- Line-safety invariant: ps2_clk_oe = 1 is permitted only in INHIBIT. Outside it, ps2_clk_oe = 0.

Optional Feature:
- Macro: PS2_TX_RETRY_EN.
- Defined:
  - Error codes 01 and 11 restart from INHIBIT with the same byte, up to MAX_RETRIES times.
  - error pulses only after the last attempt fails.
  - An internal retry counter resets on each accepted command.
- Undefined: there is no retry logic, and the first failure reports immediately.
- Code 10 never retries in either build.

Decomposition:
- Package ps2_pkg holds:
  - The state enum type.
  - Error-code localparams ERR_START, ERR_XFER, ERR_NOACK.
  - Command constants CMD_SET_LEDS = 8'hED, CMD_ECHO = 8'hEE, CMD_RESET = 8'hFF.
  - Response constants RSP_ACK = 8'hFA, RSP_RESEND = 8'hFE.
- Sub-module ps2_line_sync handles the 2FF synchronization of clock and data plus the fe pulse. It is reusable by read_keyboard.

Test Plan:
- Send 0xED. The device model clocks at 12.5 kHz after INHIBIT and ACKs. The model must capture bits 1,0,1,1,0,1,1,1 (LSB first), parity 1 and stop 1. done must pulse once, and cmd_ready must return after the lines idle.
- Send 0x00. The model must see parity 1. Send 0xFF; the model must see parity 1. Send 0x01; the model must see parity 0.
- Device never clocks. After INHIBIT_CYCLES + START_TIMEOUT_CYCLES (+2 sync), error must pulse with err_code = 01, both oe = 0, and busy low the next cycle.
- Device holds data high at the ACK edge. error must pulse with err_code = 11. With PS2_TX_RETRY_EN defined, three full INHIBIT sequences must occur before a single error pulse.
- Device stops clocking after 4 bits. error must pulse with err_code = 10 at XFER_TIMEOUT_CYCLES after the first fe.
- Assert reset during DATA bit 5. ps2_clk_oe and ps2_dat_oe must be 0 on the next cycle, with no done or error pulse. A following 0xFF command must complete normally.
